// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the 3x3 Sobel datapath: accepts raster pixels, tracks window position,
// and re-attaches delayed validity/position to the edge detector output stream.
module sobel_frame_ctrl #(
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int LB_LATENCY  = 1,
  parameter int DET_LATENCY = 2,
  localparam int XW = $clog2(IMG_WIDTH),
  localparam int YW = $clog2(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          lb_wr_en,
  output logic          lb_clr,
  input  logic          edge_in,
  output logic          out_valid,
  output logic          out_edge,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_last,
  output logic          busy,
  output logic          frame_done
);

  localparam int PIPE = LB_LATENCY + DET_LATENCY;
  localparam int CW   = $clog2(PIPE + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_reg, state_next;
  logic [XW-1:0] x_reg, x_next;
  logic [YW-1:0] y_reg, y_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic          pv_reg [PIPE];
  logic [XW-1:0] px_reg [PIPE];
  logic [YW-1:0] py_reg [PIPE];
  logic          pl_reg [PIPE];

  logic accept, win_valid, last_pix, flush;

  assign in_ready  = (state_reg == RUN);
  assign accept    = in_valid & in_ready;
  assign lb_wr_en  = accept;
  assign busy      = (state_reg != IDLE);
  assign last_pix  = (x_reg == XW'(IMG_WIDTH - 1)) && (y_reg == YW'(IMG_HEIGHT - 1));
  assign win_valid = accept && (x_reg >= XW'(2)) && (y_reg >= YW'(2));
  assign flush     = abort && (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    cnt_next   = cnt_reg;
    lb_clr     = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          lb_clr     = 1'b1;
          x_next     = '0;
          y_next     = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          x_next     = '0;
          y_next     = '0;
          state_next = IDLE;
        end else if (accept) begin
          if (x_reg == XW'(IMG_WIDTH - 1)) begin
            x_next = '0;
            if (last_pix) begin
              y_next     = '0;
              cnt_next   = CW'(1);
              state_next = DRAIN;
            end else begin
              y_next = y_reg + YW'(1);
            end
          end else begin
            x_next = x_reg + XW'(1);
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else if (cnt_reg == CW'(PIPE)) begin
          // Last drain cycle coincides with out_last at the pipe tail.
          frame_done = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pv_reg[0] <= 1'b0;
      px_reg[0] <= '0;
      py_reg[0] <= '0;
      pl_reg[0] <= 1'b0;
    end else begin
      pv_reg[0] <= win_valid && !flush;
      px_reg[0] <= x_reg - XW'(1);
      py_reg[0] <= y_reg - YW'(1);
      pl_reg[0] <= win_valid && last_pix && !flush;
    end
  end

  // Remaining stages track the line-buffer plus detector latency.
  generate
    for (genvar gi = 1; gi < PIPE; gi++) begin : g_pipe
      always_ff @(posedge clk) begin
        if (rst) begin
          pv_reg[gi] <= 1'b0;
          px_reg[gi] <= '0;
          py_reg[gi] <= '0;
          pl_reg[gi] <= 1'b0;
        end else begin
          pv_reg[gi] <= pv_reg[gi-1] && !flush;
          px_reg[gi] <= px_reg[gi-1];
          py_reg[gi] <= py_reg[gi-1];
          pl_reg[gi] <= pl_reg[gi-1] && !flush;
        end
      end
    end
  endgenerate

  assign out_valid = pv_reg[PIPE-1];
  assign out_x     = px_reg[PIPE-1];
  assign out_y     = py_reg[PIPE-1];
  assign out_last  = pl_reg[PIPE-1];
  assign out_edge  = out_valid & edge_in;

endmodule
